// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer for the AES-256 core. It generates counter blocks from
// the IV, keeps at most one core encryption in flight, buffers the keystream
// in a small FIFO and XORs it with the host data stream.
module aes_ctr_sequencer #(
    parameter int NB_W     = 16,
    parameter int KS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [127:0]    iv,
    input  logic [NB_W-1:0] num_blocks,
    output logic            busy,
    output logic            done,
    input  logic            key_rdy,
    output logic            core_start,
    output logic [127:0]    core_ctr,
    input  logic            core_done,
    input  logic [127:0]    core_ks,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [127:0]    din,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [127:0]    dout
);

    localparam int AW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    localparam int CW = $clog2(KS_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, WAITKEY, RUN, DRAIN, FINISH} state_t;

    state_t          state;
    logic [127:0]    ctr;
    logic [NB_W-1:0] total;
    logic [NB_W-1:0] issued;
    logic [NB_W-1:0] outputs;
    logic            outstanding;
    logic [127:0]    ks_mem [KS_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   ks_count;

    logic accept;
    logic out_xfer;
    logic push;
    logic issue;
    logic last_xfer;

    // Handshake and issue decisions, all derived from registered state.
    assign busy      = (state != IDLE);
    assign din_ready = (state == RUN) && (ks_count != '0) && (!dout_valid || dout_ready);
    assign accept    = din_valid && din_ready;
    assign out_xfer  = dout_valid && dout_ready;
    assign push      = (state == RUN) && core_done && outstanding;
    // Counting the in-flight op against FIFO space guarantees every
    // returning keystream block has a slot to land in.
    assign issue     = (state == RUN) && !abort && key_rdy && !outstanding &&
                       (issued < total) &&
                       ((32'(ks_count) + 32'(outstanding)) < KS_DEPTH);
    assign last_xfer = out_xfer && (outputs == total - NB_W'(1));

    // Keystream storage; occupancy lives in ks_count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push)
            ks_mem[wr_ptr] <= core_ks;
    end

    // Main sequencer FSM with FIFO pointers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ctr         <= '0;
            total       <= '0;
            issued      <= '0;
            outputs     <= '0;
            outstanding <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ks_count    <= '0;
            done        <= 1'b0;
            core_start  <= 1'b0;
            core_ctr    <= '0;
            dout_valid  <= 1'b0;
            dout        <= '0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is ignored here, so start always wins.
                    if (start) begin
                        ctr         <= iv;
                        total       <= num_blocks;
                        issued      <= '0;
                        outputs     <= '0;
                        outstanding <= 1'b0;
                        state       <= (num_blocks == '0) ? FINISH : WAITKEY;
                    end
                end
                WAITKEY: begin
                    if (abort)
                        state <= IDLE;
                    else if (key_rdy)
                        state <= RUN;
                end
                RUN: begin
                    // issue needs no op in flight and push needs one, so
                    // they never coincide.
                    if (issue) begin
                        core_start  <= 1'b1;
                        core_ctr    <= ctr;
                        ctr         <= {ctr[127:64], ctr[63:0] + 64'd1};
                        issued      <= issued + NB_W'(1);
                        outstanding <= 1'b1;
                    end else if (push) begin
                        outstanding <= 1'b0;
                    end

                    if (abort) begin
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        ks_count   <= '0;
                        dout_valid <= 1'b0;
                        // An op completing this very cycle needs no drain.
                        state      <= (outstanding && !core_done) ? DRAIN : IDLE;
                    end else begin
                        if (push)
                            wr_ptr <= wr_ptr + AW'(1);
                        if (accept)
                            rd_ptr <= rd_ptr + AW'(1);
                        ks_count <= ks_count + CW'(push) - CW'(accept);

                        if (accept) begin
                            dout       <= din ^ ks_mem[rd_ptr];
                            dout_valid <= 1'b1;
                        end else if (out_xfer) begin
                            dout_valid <= 1'b0;
                        end

                        if (out_xfer)
                            outputs <= outputs + NB_W'(1);
                        if (last_xfer)
                            state <= FINISH;
                    end
                end
                DRAIN: begin
                    // The late keystream belongs to a cancelled message.
                    if (core_done) begin
                        outstanding <= 1'b0;
                        state       <= IDLE;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed bench for aes_ctr_sequencer: table of whole messages plus
// hand-written abort and asynchronous-reset sequences.
module tb_aes_ctr_sequencer;

    localparam int NB_W     = 16;
    localparam int KS_DEPTH = 2;
    localparam logic [127:0] KS_MASK = {16{8'hA5}};

    logic            clk = 1'b0;
    logic            rst;
    logic            start, abort, key_rdy;
    logic [127:0]    iv;
    logic [NB_W-1:0] num_blocks;
    logic            busy, done;
    logic            core_start, core_done;
    logic [127:0]    core_ctr, core_ks;
    logic            din_valid, din_ready, dout_valid, dout_ready;
    logic [127:0]    din, dout;

    aes_ctr_sequencer #(.NB_W(NB_W), .KS_DEPTH(KS_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iv(iv),
        .num_blocks(num_blocks), .busy(busy), .done(done), .key_rdy(key_rdy),
        .core_start(core_start), .core_ctr(core_ctr), .core_done(core_done),
        .core_ks(core_ks), .din_valid(din_valid), .din_ready(din_ready),
        .din(din), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model state, shared with the stimulus side.
    int           lat = 1;
    logic         pend = 1'b0;
    int           cd = 0;
    logic [127:0] pend_ctr = '0;
    int           n_starts = 0;
    int           start_idx = 0;
    logic [127:0] cur_iv = '0;
    logic [127:0] last_ctr = '0;
    logic         stray = 1'b0;

    // Encryption core model: ks = ctr ^ A5..A5 after 'lat' cycles.
    initial begin : core_model
        core_done = 1'b0;
        core_ks   = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (!rst) pend = 1'b0;
            if (stray) begin
                core_done = 1'b1;
                core_ks   = '1;
                stray     = 1'b0;
            end else if (pend) begin
                if (cd == 0) begin
                    core_done = 1'b1;
                    core_ks   = pend_ctr ^ KS_MASK;
                    pend      = 1'b0;
                end else cd--;
            end
            if (pend) chk("core_ctr_stable", core_ctr, pend_ctr);
            if (rst && core_start) begin
                chk("core_ctr_seq", core_ctr, {cur_iv[127:64], cur_iv[63:0] + 64'(start_idx)});
                start_idx++;
                n_starts++;
                last_ctr = core_ctr;
                pend     = 1'b1;
                pend_ctr = core_ctr;
                cd       = lat - 1;
            end
        end
    end

    function automatic logic [127:0] mk_din(input int m, input int i);
        return {32'hC0DE_0000 ^ 32'(m), 32'(i), 32'h5A5A_0F0F, 32'(i) * 32'h0101_0101};
    endfunction

    function automatic logic [127:0] exp_dout(input int m, input int i);
        return mk_din(m, i) ^ {cur_iv[127:64], cur_iv[63:0] + 64'(i)} ^ KS_MASK;
    endfunction

    typedef struct {
        logic [127:0] iv;
        int           nb;
        int           lat;
        int           stall;
        logic [127:0] exp_last;
        int           exp_done_cyc;
    } vec_t;

    vec_t tbl [4];

    task automatic run_msg(input int m, input vec_t v);
        int sent, recv, cyc, done_cyc;
        logic got_done, rdy_seen, stall_cap, acc;
        logic [127:0] stall_dout;
        lat = v.lat; cur_iv = v.iv; start_idx = 0; n_starts = 0; last_ctr = '0;
        @(posedge clk); #1;
        iv = v.iv; num_blocks = NB_W'(v.nb); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sent = 0; recv = 0; cyc = 0; done_cyc = -1;
        got_done = 1'b0; rdy_seen = 1'b0; stall_cap = 1'b0; stall_dout = '0;
        din_valid = (v.nb > 0); din = mk_din(m, 0); dout_ready = (v.stall == 0);
        while (!got_done && cyc < 3000) begin
            @(negedge clk);
            acc = din_valid && din_ready;
            if (din_ready) rdy_seen = 1'b1;
            if (dout_valid && dout_ready) begin
                chk($sformatf("dout m%0d b%0d", m, recv), dout, exp_dout(m, recv));
                recv++;
            end
            if (v.stall > 0 && cyc < v.stall && dout_valid && !stall_cap) begin
                stall_cap  = 1'b1;
                stall_dout = dout;
            end
            if (v.stall > 0 && cyc == v.stall - 1) begin
                chk("stall_starts", 128'(n_starts), 128'(KS_DEPTH + 1));
                chk("stall_dout_valid", 128'(dout_valid), 128'(1));
                chk("stall_dout_stable", dout, stall_dout);
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                din       = mk_din(m, sent);
                din_valid = (sent < v.nb);
            end
            dout_ready = (cyc >= v.stall);
        end
        chk($sformatf("done_seen m%0d", m), 128'(got_done), 128'(1));
        chk($sformatf("blocks_out m%0d", m), 128'(recv), 128'(v.nb));
        chk($sformatf("core_starts m%0d", m), 128'(n_starts), 128'(v.nb));
        chk($sformatf("last_ctr m%0d", m), last_ctr, v.exp_last);
        if (v.exp_done_cyc >= 0)
            chk("done_latency", 128'(done_cyc), 128'(v.exp_done_cyc));
        if (v.nb == 0)
            chk("din_ready_never", 128'(rdy_seen), 128'(0));
        chk($sformatf("done_single m%0d", m), 128'(done), 128'(0));
        chk($sformatf("busy_after m%0d", m), 128'(busy), 128'(0));
        din_valid  = 1'b0;
        dout_ready = 1'b0;
    endtask

    initial begin : main
        int w;
        logic seen_done;
        vec_t v;

        tbl[0] = '{iv: 128'h5, nb: 3, lat: 10, stall: 0, exp_last: 128'h7, exp_done_cyc: -1};
        tbl[1] = '{iv: {64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF}, nb: 2, lat: 3, stall: 0,
                   exp_last: {64'h1234_5678_9ABC_DEF0, 64'h0}, exp_done_cyc: -1};
        tbl[2] = '{iv: 128'hABCD, nb: 0, lat: 1, stall: 0, exp_last: 128'h0, exp_done_cyc: 1};
        tbl[3] = '{iv: 128'h10, nb: 4, lat: 1, stall: 20, exp_last: 128'h13, exp_done_cyc: -1};

        rst = 1'b0; start = 1'b0; abort = 1'b0; key_rdy = 1'b1;
        iv = '0; num_blocks = '0; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_core_start", 128'(core_start), 128'(0));
        chk("rst_dout_valid", 128'(dout_valid), 128'(0));
        chk("rst_core_ctr", core_ctr, 128'(0));
        chk("rst_dout", dout, 128'(0));
        @(posedge clk); #2;
        rst = 1'b1;

        for (int i = 0; i < 4; i++) run_msg(i, tbl[i]);

        // Abort with an op outstanding: drain, no done, then a clean message.
        lat = 12; cur_iv = 128'h77; start_idx = 0; n_starts = 0;
        @(posedge clk); #1;
        iv = 128'h77; num_blocks = NB_W'(3); start = 1'b1; dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!core_start && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("abort_core_start_seen", 128'(core_start), 128'(1));
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("drain_busy", 128'(busy), 128'(1));
        chk("drain_dout_valid", 128'(dout_valid), 128'(0));
        chk("drain_din_ready", 128'(din_ready), 128'(0));
        w = 0; seen_done = 1'b0;
        while (busy && w < 50) begin
            @(posedge clk); #1;
            w++;
            if (done) seen_done = 1'b1;
        end
        chk("drain_len", 128'(w), 128'(9));
        chk("abort_no_done", 128'(seen_done), 128'(0));
        chk("abort_dout_valid", 128'(dout_valid), 128'(0));
        chk("abort_done_now", 128'(done), 128'(0));
        dout_ready = 1'b0;
        v = '{iv: 128'h88, nb: 1, lat: 2, stall: 0, exp_last: 128'h88, exp_done_cyc: -1};
        run_msg(5, v);

        // Asynchronous reset in the middle of RUN with dout_valid high.
        lat = 1; cur_iv = 128'h300; start_idx = 0; n_starts = 0;
        @(posedge clk); #1;
        iv = 128'h300; num_blocks = NB_W'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; din_valid = 1'b1; din = mk_din(6, 0); dout_ready = 1'b0;
        w = 0;
        while (!dout_valid && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk("rst_pre_dout_valid", 128'(dout_valid), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_core_start", 128'(core_start), 128'(0));
        chk("arst_din_ready", 128'(din_ready), 128'(0));
        chk("arst_dout_valid", 128'(dout_valid), 128'(0));
        chk("arst_core_ctr", core_ctr, 128'(0));
        chk("arst_dout", dout, 128'(0));
        @(posedge clk); #2;
        rst = 1'b1; din_valid = 1'b0; stray = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stray_busy", 128'(busy), 128'(0));
        chk("stray_din_ready", 128'(din_ready), 128'(0));
        chk("stray_dout_valid", 128'(dout_valid), 128'(0));
        v = '{iv: 128'h400, nb: 1, lat: 1, stall: 0, exp_last: 128'h400, exp_done_cyc: -1};
        run_msg(7, v);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
Sequences the AES-256 encryption core for CTR-mode operation. It generates successive counter blocks from a 128-bit IV, issues one core encryption at a time, and buffers the returned keystream in a small FIFO. It XORs the keystream with a valid/ready input data stream to produce the output stream. It sits between the host data path and the encryption core/key-expansion pair.

Parameters:
NB_W, 16, width of block-count field (max message = 2^NB_W-1 blocks)
KS_DEPTH, 2, keystream FIFO depth in 128-bit entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin a message; sampled only in IDLE
abort  in  1  cancel current message; ignored in IDLE
iv  in  128  initial counter block, captured on accepted start
num_blocks  in  NB_W  message length in blocks, captured on accepted start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when message completes (not on abort)
key_rdy  in  1  round keys valid from key expansion (level)
core_start  out  1  one-cycle pulse launching one core encryption
core_ctr  out  128  counter block for the core, stable from core_start until core_done
core_done  in  1  one-cycle pulse, core_ks valid this cycle
core_ks  in  128  encrypted counter (keystream) block
din_valid / din_ready  in / out  1  input data handshake
din  in  128  plaintext/ciphertext block
dout_valid / dout_ready  out / in  1  output data handshake
dout  out  128  din XOR keystream

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, core_start, din_ready, dout_valid=0; core_ctr, dout=0; FIFO empty; all counters=0.
- States: IDLE, WAITKEY, RUN, DRAIN, FINISH.
- IDLE: start=1 -> capture iv into ctr and num_blocks into total, clear issued/consumed/outputs. Go to FINISH if num_blocks==0, else WAITKEY.
- WAITKEY: go to RUN on the first cycle key_rdy=1.
- RUN, core issue: pulse core_start with core_ctr=ctr when all hold: key_rdy=1, no op outstanding, issued<total, fifo_count+outstanding<KS_DEPTH. At most one op is outstanding.
- RUN, counter increment: on issue, ctr[63:0] increments mod 2^64 (wrap FFFF_FFFF_FFFF_FFFF -> 0); ctr[127:64] is unchanged.
- RUN, keystream capture: core_done with an op outstanding pushes core_ks into the FIFO and clears outstanding. core_done with no op outstanding is ignored.
- din_ready=1 in RUN iff FIFO nonempty and (dout_valid=0 or dout_ready=1), i.e. combinational from registered state plus dout_ready.
- Input accept (din_valid & din_ready): pop the FIFO head, set dout<=din^head and dout_valid<=1. Latency is 1 cycle from din to dout.
- Output: dout_valid holds until dout_ready; dout is stable while stalled. A transfer with no new accept clears dout_valid.
- FIFO push and pop in the same cycle are allowed; the count is unchanged.
- Completion: when the output transfer of block total-1 completes, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- abort in RUN/WAITKEY: flush the FIFO and clear dout_valid/din_ready next cycle. Go to DRAIN if an op is outstanding, else IDLE. No done pulse is issued.
- DRAIN: wait for core_done, discard core_ks, then go to IDLE.
- abort and start in the same cycle in IDLE: start wins, abort is ignored. abort in DRAIN/FINISH has no effect.
- key_rdy dropping mid-RUN: stall new issues only; outstanding ops and data flow continue.

Test Plan:
1. iv=0x00..00_0000000000000005, num_blocks=3, core returning ks=ctr^0xA5..A5 after 10 cycles -> core_ctr sequence ...05, ...06, ...07; dout=din^ks for each block; a single done pulse after the 3rd output transfer; busy low the following cycle.
2. iv low half=FFFF_FFFF_FFFF_FFFF, upper=0x1234..., num_blocks=2 -> second core_ctr low half=0, upper half unchanged.
3. num_blocks=0 -> done pulse two cycles after start; zero core_start pulses; din_ready never asserted.
4. dout_ready held low for 20 cycles with core latency 1, num_blocks=4 -> at most KS_DEPTH (2) entries buffered plus 1 in dout; core_start stops; dout stable; all 4 blocks correct once ready rises.
5. abort asserted 3 cycles after core_start (op outstanding) -> DRAIN; the later core_done is discarded; IDLE reached with no done pulse and dout_valid=0. A following start with num_blocks=1 works normally.
6. rst pulled low mid-RUN with dout_valid=1 -> all outputs 0 immediately (asynchronous). After release, state is IDLE and stray core_done pulses are ignored.
